fft2_din_mem_responder: RTL and testbench
=========================================

// Module: fft2_din_mem_responder
// PURPOSE
//  Responder end of the fft2 data-in read protocol. Holds one FFT_SIZE x FFT_SIZE complex input frame.
//  Answers FFT-core read requests (addr + rd strobe) with RE/IM data and a valid strobe after RD_LAT cycles.
//  The frame is loaded beforehand through a streaming load port.
//  Sits between the input-frame source and the fft2 core; it is also the synthesizable model used as the fft2 bench memory.
// PARAMETERS
//  DATA_WIDTH  32  width of each real/imag word
//  FFT_SIZE    16  frame side; depth = FFT_SIZE*FFT_SIZE; AW = $clog2(depth)
//  RD_LAT      2   read-request-to-response latency in cycles, legal 1..4
// PORTS
//  clk            in   1   clock
//  rst            in   1   synchronous active-high reset
//  load_start_i   in   1   begin (re)loading a frame at address 0
//  load_valid_i   in   1   load word valid
//  load_re_i      in   DW  load real word
//  load_im_i      in   DW  load imag word
//  load_ready_o   out  1   high in LOAD state; words accepted on load_valid_i && load_ready_o
//  load_done_o    out  1   one-cycle pulse when the last word (addr depth-1) is written
//  frame_rdy_o    out  1   high in READY state
//  data_i_addr_i  in   AW  read address from core
//  data_rd_i      in   1   read request strobe from core
//  dataRE_o       out  DW  read data, real
//  dataIM_o       out  DW  read data, imag
//  data_rd_o      out  1   response valid, exactly RD_LAT cycles after the matching request
//  rd_err_o       out  1   qualifies data_rd_o: request was issued outside READY
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, wr_cnt 0, response pipeline flushed. Memory contents are not cleared.
//  FSM IDLE -load_start_i-> LOAD; LOAD -accepted word at wr_cnt==depth-1-> READY; READY -load_start_i-> LOAD.
//  load_start_i while in LOAD restarts at wr_cnt=0; a load_valid_i in that same cycle is dropped.
//  LOAD: each accepted word writes mem[wr_cnt] and increments wr_cnt. Accepting the last word pulses load_done_o,
//   moves to READY next cycle and wraps wr_cnt to 0. load_valid_i outside LOAD is ignored.
//  Read request, cycle t:
//   - READY: mem[data_i_addr_i] is sampled at t.
//   - at t+RD_LAT: data_rd_o=1 with that data and rd_err_o=0.
//  Request at t outside READY: at t+RD_LAT, data_rd_o=1, rd_err_o=1, dataRE_o=dataIM_o=0.
//  Fully pipelined: one request per cycle, no back-pressure; responses stay in request order.
//  When data_rd_o=0: dataRE_o, dataIM_o and rd_err_o are 0.
//  READY->LOAD transition: requests already in the pipeline still complete with their sampled data.
//  Reset mid-operation: all in-flight responses are discarded.
//  Address >= depth (non-power-of-2 FFT_SIZE only): response has rd_err_o=1 and zero data.
// CONFIGURATION
//  FFT2_DIN_ERR_CNT_EN defined:
//   - adds output err_cnt_o[15:0], count of responses with rd_err_o=1.
//   - saturates at 16'hFFFF; cleared by rst and by load_start_i.
//  Not defined: port and counter absent; all other behaviour identical.
// STRUCTURE
//  fft2_din_pkg:
//   - fft2_din_state_e {IDLE,LOAD,READY}
//   - cplx_t struct {re,im}
//   - function addr_w(fft_size)
//   - localparam RD_LAT_MAX=4
//  Sub-module fft2_din_rd_pipe: RD_LAT-deep valid/err/cplx_t delay line with sync clear. The top holds the FSM, counter and RAM.
// TESTING
//  1 FFT_SIZE=4, RD_LAT=2: load mem[i]={i,~i} for 16 words
//    -> load_done_o pulses on word 15; frame_rdy_o high next cycle.
//  2 Read addr 0..15 back-to-back
//    -> data_rd_o high for 16 cycles starting 2 cycles after the first request; RE=i, IM=~i, rd_err_o=0.
//  3 Read addr 5 in IDLE
//    -> 2 cycles later data_rd_o=1, rd_err_o=1, RE=IM=0; with FFT2_DIN_ERR_CNT_EN, err_cnt_o=1.
//  4 Issue reads at addr 3 and 4, then load_start_i in the next cycle
//    -> both responses still return old data; frame_rdy_o=0 and load_ready_o=1.
//  5 rst asserted during LOAD at word 7, then a full reload
//    -> pending responses dropped, outputs 0; reload succeeds from address 0.
//  6 Sweep RD_LAT=1 and 4 with random addresses
//    -> scoreboard checks latency is exact and data matches.

Source files
------------

// File: rtl/fft2_din_pkg.sv
// Shared types and helpers for the fft2 data-in memory responder.
package fft2_din_pkg;

  localparam int unsigned RD_LAT_MAX = 4;
  localparam int unsigned CPLX_W     = 32;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    READY
  } fft2_din_state_e;

  typedef struct packed {
    logic [CPLX_W-1:0] re;
    logic [CPLX_W-1:0] im;
  } cplx_t;

  function automatic int unsigned addr_w(input int unsigned fft_size);
    return (fft_size * fft_size > 1) ? $clog2(fft_size * fft_size) : 1;
  endfunction

endpackage

// File: rtl/fft2_din_rd_pipe.sv
// Fixed-latency valid/err/data delay line for read responses, synchronously cleared.
module fft2_din_rd_pipe
  import fft2_din_pkg::*;
#(
  parameter int unsigned RD_LAT = 2,
  parameter type         data_t = cplx_t
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  valid_i,
  input  logic  err_i,
  input  data_t data_i,
  output logic  valid_o,
  output logic  err_o,
  output data_t data_o
);

  logic [RD_LAT-1:0] valid_q;
  logic [RD_LAT-1:0] err_q;
  data_t             data_q [RD_LAT];

  // Data is zeroed at entry so the output needs no gating on valid/err.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      err_q   <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      valid_q[0] <= valid_i;
      err_q[0]   <= valid_i && err_i;
      data_q[0]  <= (valid_i && !err_i) ? data_i : '0;
      for (int i = 1; i < RD_LAT; i++) begin
        valid_q[i] <= valid_q[i-1];
        err_q[i]   <= err_q[i-1];
        data_q[i]  <= data_q[i-1];
      end
    end
  end

  assign valid_o = valid_q[RD_LAT-1];
  assign err_o   = err_q[RD_LAT-1];
  assign data_o  = data_q[RD_LAT-1];

endmodule

// File: rtl/fft2_din_mem_responder.sv
// Frame memory answering fft2 core reads after a fixed latency; loaded via a streaming port.
// Optional FFT2_DIN_ERR_CNT_EN adds a saturating error-response counter output.
module fft2_din_mem_responder
  import fft2_din_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH = 32,
  parameter  int unsigned FFT_SIZE   = 16,
  parameter  int unsigned RD_LAT     = 2,
  localparam int unsigned DEPTH      = FFT_SIZE * FFT_SIZE,
  localparam int unsigned AW         = addr_w(FFT_SIZE)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_start_i,
  input  logic                  load_valid_i,
  input  logic [DATA_WIDTH-1:0] load_re_i,
  input  logic [DATA_WIDTH-1:0] load_im_i,
  output logic                  load_ready_o,
  output logic                  load_done_o,
  output logic                  frame_rdy_o,
  input  logic [AW-1:0]         data_i_addr_i,
  input  logic                  data_rd_i,
  output logic [DATA_WIDTH-1:0] dataRE_o,
  output logic [DATA_WIDTH-1:0] dataIM_o,
  output logic                  data_rd_o,
  output logic                  rd_err_o
`ifdef FFT2_DIN_ERR_CNT_EN
  ,
  output logic [15:0]           err_cnt_o
`endif
);

  // Out-of-range latencies are clamped to the legal 1..RD_LAT_MAX window.
  localparam int unsigned LAT = (RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX :
                                (RD_LAT == 0)         ? 1 : RD_LAT;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] re;
    logic [DATA_WIDTH-1:0] im;
  } word_t;

  fft2_din_state_e       state_q;
  logic [AW-1:0]         wr_cnt_q;
  logic [DATA_WIDTH-1:0] mem_re [DEPTH];
  logic [DATA_WIDTH-1:0] mem_im [DEPTH];

  logic  wr_en;
  logic  last_word;
  logic  addr_oob;
  logic  req_err;
  word_t req_data;
  word_t rsp_data;
  logic  rsp_valid;
  logic  rsp_err;

  assign last_word = (wr_cnt_q == AW'(DEPTH - 1));
  assign wr_en     = !rst && (state_q == LOAD) && load_valid_i && !load_start_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      wr_cnt_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (load_start_i) begin
            state_q  <= LOAD;
            wr_cnt_q <= '0;
          end
        end
        LOAD: begin
          // A restart wins over a word presented in the same cycle.
          if (load_start_i) begin
            wr_cnt_q <= '0;
          end else if (load_valid_i) begin
            if (last_word) begin
              state_q  <= READY;
              wr_cnt_q <= '0;
            end else begin
              wr_cnt_q <= wr_cnt_q + AW'(1);
            end
          end
        end
        READY: begin
          if (load_start_i) begin
            state_q  <= LOAD;
            wr_cnt_q <= '0;
          end
        end
        default: begin
          state_q  <= IDLE;
          wr_cnt_q <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_re[wr_cnt_q] <= load_re_i;
      mem_im[wr_cnt_q] <= load_im_i;
    end
  end

  assign addr_oob = ({1'b0, data_i_addr_i} >= (AW + 1)'(DEPTH));

  always_comb begin
    req_err  = (state_q != READY) || addr_oob;
    req_data = '0;
    if (!req_err) begin
      req_data.re = mem_re[data_i_addr_i];
      req_data.im = mem_im[data_i_addr_i];
    end
  end

  fft2_din_rd_pipe #(
    .RD_LAT (LAT),
    .data_t (word_t)
  ) u_rd_pipe (
    .clk     (clk),
    .rst     (rst),
    .valid_i (data_rd_i),
    .err_i   (req_err),
    .data_i  (req_data),
    .valid_o (rsp_valid),
    .err_o   (rsp_err),
    .data_o  (rsp_data)
  );

  assign load_ready_o = (state_q == LOAD);
  assign frame_rdy_o  = (state_q == READY);
  assign load_done_o  = wr_en && last_word;
  assign data_rd_o    = rsp_valid;
  assign rd_err_o     = rsp_err;
  assign dataRE_o     = rsp_data.re;
  assign dataIM_o     = rsp_data.im;

`ifdef FFT2_DIN_ERR_CNT_EN
  logic [15:0] err_cnt_q;

  always_ff @(posedge clk) begin
    if (rst || load_start_i) begin
      err_cnt_q <= '0;
    end else if (rsp_valid && rsp_err && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  assign err_cnt_o = err_cnt_q;
`endif

endmodule

// File: tb/tb_fft2_din_mem_responder.sv
// Scoreboard bench: three responders (RD_LAT 2, 1, 4) share one stimulus stream.
module tb_fft2_din_mem_responder;

  localparam int NDUT = 3;

  function automatic int lat_of(input int g);
    case (g)
      0:       return 2;
      1:       return 1;
      default: return 4;
    endcase
  endfunction

  typedef struct {
    int          due;
    logic        err;
    logic [31:0] re;
    logic [31:0] im;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        load_start;
  logic        load_valid;
  logic [31:0] load_re;
  logic [31:0] load_im;
  logic [3:0]  rd_addr;
  logic        rd_req;

  logic        ld_ready [NDUT];
  logic        ld_done  [NDUT];
  logic        frdy     [NDUT];
  logic        rd_v     [NDUT];
  logic        rd_e     [NDUT];
  logic [31:0] rd_re    [NDUT];
  logic [31:0] rd_im    [NDUT];
`ifdef FFT2_DIN_ERR_CNT_EN
  logic [15:0] ecnt     [NDUT];
`endif

  exp_t        sb_q [NDUT][$];
  int          n_vec = 0;
  int          n_bad = 0;
  int          cyc = 0;
  bit          mon_en = 0;
  bit          chk_en = 0;

  int          m_state;  // 0 idle, 1 load, 2 ready
  int          m_wcnt;
  logic [31:0] m_re [16];
  logic [31:0] m_im [16];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    exp_t e;
    int   ecnt_m = 0;
    logic pop_err;

    fft2_din_mem_responder #(
      .DATA_WIDTH (32),
      .FFT_SIZE   (4),
      .RD_LAT     (lat_of(g))
    ) u_dut (
      .clk           (clk),
      .rst           (rst),
      .load_start_i  (load_start),
      .load_valid_i  (load_valid),
      .load_re_i     (load_re),
      .load_im_i     (load_im),
      .load_ready_o  (ld_ready[g]),
      .load_done_o   (ld_done[g]),
      .frame_rdy_o   (frdy[g]),
      .data_i_addr_i (rd_addr),
      .data_rd_i     (rd_req),
      .dataRE_o      (rd_re[g]),
      .dataIM_o      (rd_im[g]),
      .data_rd_o     (rd_v[g]),
      .rd_err_o      (rd_e[g])
`ifdef FFT2_DIN_ERR_CNT_EN
      ,
      .err_cnt_o     (ecnt[g])
`endif
    );

    always @(negedge clk) begin
      if (mon_en) begin
        pop_err = 1'b0;
        // A reset in this cycle kills everything not already at the output.
        if (rst) begin
          while (sb_q[g].size() > 0 && sb_q[g][$].due > cyc) void'(sb_q[g].pop_back());
        end
        if (sb_q[g].size() > 0 && sb_q[g][0].due == cyc) begin
          e = sb_q[g].pop_front();
          pop_err = e.err;
          check($sformatf("L%0d rsp_valid", lat_of(g)), 32'(rd_v[g]), 32'd1);
          check($sformatf("L%0d rsp_err", lat_of(g)), 32'(rd_e[g]), 32'(e.err));
          check($sformatf("L%0d rsp_re", lat_of(g)), rd_re[g], e.re);
          check($sformatf("L%0d rsp_im", lat_of(g)), rd_im[g], e.im);
        end else begin
          check($sformatf("L%0d idle_valid", lat_of(g)), 32'(rd_v[g]), 32'd0);
          check($sformatf("L%0d idle_data", lat_of(g)), rd_re[g] | rd_im[g] | 32'(rd_e[g]), 32'd0);
        end
`ifdef FFT2_DIN_ERR_CNT_EN
        check($sformatf("L%0d err_cnt", lat_of(g)), 32'(ecnt[g]), 32'(ecnt_m));
        ecnt_m = (rst || load_start) ? 0 : ecnt_m + int'(pop_err);
`endif
      end
    end
  end

  task automatic step(input logic r, input logic st, input logic v, input logic [31:0] dre,
                      input logic [31:0] dim, input logic rq, input logic [3:0] a);
    exp_t ex;
    logic exp_done;
    @(posedge clk);
    #1;
    rst        = r;
    load_start = st;
    load_valid = v;
    load_re    = dre;
    load_im    = dim;
    rd_req     = rq;
    rd_addr    = a;
    if (rq && !r) begin
      for (int g = 0; g < NDUT; g++) begin
        ex.due = cyc + lat_of(g);
        ex.err = (m_state != 2);
        ex.re  = ex.err ? 32'd0 : m_re[a];
        ex.im  = ex.err ? 32'd0 : m_im[a];
        sb_q[g].push_back(ex);
      end
    end
    exp_done = !r && (m_state == 1) && v && !st && (m_wcnt == 15);
    @(negedge clk);
    if (chk_en) begin
      check("load_done", 32'(ld_done[0]), 32'(exp_done));
      check("load_ready", 32'(ld_ready[0]), 32'(m_state == 1));
      check("frame_rdy", 32'(frdy[0]), 32'(m_state == 2));
    end
    if (r) begin
      m_state = 0;
      m_wcnt  = 0;
    end else if (st) begin
      m_state = 1;
      m_wcnt  = 0;
    end else if (m_state == 1 && v) begin
      m_re[m_wcnt] = dre;
      m_im[m_wcnt] = dim;
      if (m_wcnt == 15) begin
        m_state = 2;
        m_wcnt  = 0;
      end else begin
        m_wcnt++;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 32'd0, 32'd0, 0, 4'd0);
  endtask

  task automatic load_words(input int first, input int last, input int base);
    for (int i = first; i <= last; i++) begin
      step(0, 0, 1, 32'(base + i), ~32'(base + i), 0, 4'd0);
    end
  endtask

  task automatic read_all();
    for (int i = 0; i < 16; i++) step(0, 0, 0, 32'd0, 32'd0, 1, 4'(i));
    idle(6);
  endtask

  initial begin
    clk = 0; rst = 1; load_start = 0; load_valid = 0;
    load_re = '0; load_im = '0; rd_addr = '0; rd_req = 0;
    m_state = 0; m_wcnt = 0;
    repeat (3) @(posedge clk);
    chk_en = 1;
    mon_en = 1;
    step(1, 0, 0, 32'd0, 32'd0, 0, 4'd0);
    idle(2);

    // Read while IDLE: error response with zero data.
    step(0, 0, 0, 32'd0, 32'd0, 1, 4'd5);
    idle(6);

    // Load mem[i] = {i, ~i}, then read the whole frame back-to-back.
    step(0, 1, 0, 32'd0, 32'd0, 0, 4'd0);
    load_words(0, 15, 0);
    idle(2);
    read_all();

    // Reads just before a reload must return the old frame.
    step(0, 0, 0, 32'd0, 32'd0, 1, 4'd3);
    step(0, 0, 0, 32'd0, 32'd0, 1, 4'd4);
    step(0, 1, 0, 32'd0, 32'd0, 0, 4'd0);
    idle(1);
    load_words(0, 15, 100);
    read_all();

    // Reset mid-load with error reads in flight, then a full reload.
    step(0, 1, 0, 32'd0, 32'd0, 0, 4'd0);
    load_words(0, 4, 200);
    step(0, 0, 1, 32'd205, ~32'd205, 1, 4'd1);
    step(0, 0, 1, 32'd206, ~32'd206, 1, 4'd2);
    step(1, 0, 1, 32'd207, ~32'd207, 0, 4'd0);
    step(1, 0, 0, 32'd0, 32'd0, 0, 4'd0);
    idle(5);
    step(0, 1, 0, 32'd0, 32'd0, 0, 4'd0);
    load_words(0, 15, 300);
    read_all();

    // Random reads across all latencies, with stray load words ignored in READY.
    for (int i = 0; i < 300; i++) begin
      step(0, 0, 1'($urandom_range(0, 1)), $urandom, $urandom,
           1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
    end
    idle(8);

    for (int g = 0; g < NDUT; g++) begin
      check($sformatf("L%0d sb_drain", lat_of(g)), 32'(sb_q[g].size()), 32'd0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not complete (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
